// File: rtl/ranging_controller.sv
// ranging_controller
//   Drives an ultrasonic ranging sensor once per measurement period: raises the
//   trigger, times the echo pulse and converts its width to a distance. Each
//   result goes into a DEPTH-entry ring buffer. The newest entry and the entry
//   it overwrote are presented to a downstream running averager.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   enable        permits new measurements to start
//   echo          sensor echo pin (asynchronous, synchronised here)
//   trig          sensor trigger pin
//   newest        most recently stored distance
//   oldest        entry overwritten by the most recent store (0 before wrap)
//   sample_valid  one-cycle pulse when newest/oldest change
//   timeout       last measurement timed out; held until the next store
//   filled        DEPTH stores completed since reset
module ranging_controller #(
    parameter int unsigned TRIG_CYCLES     = 400,
    parameter int unsigned PERIOD_CYCLES   = 2400000,
    parameter int unsigned TIMEOUT_CYCLES  = 1520000,
    parameter int unsigned CYCLES_PER_UNIT = 2320,
    parameter int unsigned MAX_DIST        = 400,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned DIST_W          = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] newest,
    output logic [DIST_W-1:0] oldest,
    output logic              sample_valid,
    output logic              timeout,
    output logic              filled
);

    localparam int unsigned PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PRE_W = $clog2(CYCLES_PER_UNIT + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PER_W-1:0]  PERIOD_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [PER_W-1:0]  TRIG_LAST   = PER_W'(TRIG_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(CYCLES_PER_UNIT - 1);
    localparam logic [DIST_W-1:0] MAX_D       = DIST_W'(MAX_DIST);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_MEAS  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]        state_q,   state_d;
    logic              echo_s1_q, echo_s2_q;
    logic [PER_W-1:0]  period_q,  period_d;
    logic [TMO_W-1:0]  tmo_q,     tmo_d;
    logic [PRE_W-1:0]  pre_q,     pre_d;
    logic [DIST_W-1:0] dcnt_q,    dcnt_d;
    logic [DIST_W-1:0] dist_q,    dist_d;
    logic              flag_q,    flag_d;
    logic [PTR_W-1:0]  wp_q,      wp_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DIST_W-1:0] newest_q,  newest_d;
    logic [DIST_W-1:0] oldest_q,  oldest_d;
    logic              sv_q,      sv_d;
    logic              timeout_q, timeout_d;
    logic              filled_q,  filled_d;
    logic              trig_q,    trig_d;
    logic [DIST_W-1:0] mem_q [DEPTH];

    always_comb begin
        state_d   = state_q;
        // The period counter doubles as the trigger-width timer: TRIG always
        // occupies counts 0..TRIG_CYCLES-1 of a period.
        if (state_q == S_IDLE || period_q == PERIOD_LAST) begin
            period_d = '0;
        end else begin
            period_d = period_q + 1'b1;
        end
        tmo_d     = tmo_q;
        pre_d     = pre_q;
        dcnt_d    = dcnt_q;
        dist_d    = dist_q;
        flag_d    = flag_q;
        wp_d      = wp_q;
        cnt_d     = cnt_q;
        newest_d  = newest_q;
        oldest_d  = oldest_q;
        sv_d      = 1'b0;
        timeout_d = timeout_q;
        filled_d  = filled_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (period_q == TRIG_LAST) begin
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (echo_s2_q) begin
                    state_d = S_MEAS;
                    tmo_d   = '0;
                    pre_d   = '0;
                    dcnt_d  = '0;
                end else if (tmo_q == TMO_LAST) begin
                    dist_d  = MAX_D;
                    flag_d  = 1'b1;
                    state_d = S_STORE;
                end
            end
            S_MEAS: begin
                // Every MEASURE cycle is counted, including the one that sees
                // the fall: the rise was seen one cycle before MEASURE began,
                // so this makes the count equal the synchronised echo width.
                tmo_d = tmo_q + 1'b1;
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (dcnt_q != MAX_D) begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                if (!echo_s2_q) begin
                    dist_d  = dcnt_d;
                    flag_d  = 1'b0;
                    state_d = S_STORE;
                end else if (tmo_q == TMO_LAST) begin
                    dist_d  = MAX_D;
                    flag_d  = 1'b1;
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                oldest_d  = mem_q[wp_q];
                newest_d  = dist_q;
                timeout_d = flag_q;
                sv_d      = 1'b1;
                wp_d      = wp_q + 1'b1;
                cnt_d     = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
                filled_d  = (cnt_d == CNT_FULL);
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (period_q == PERIOD_LAST) begin
                    state_d = enable ? S_TRIG : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        trig_d = (state_d == S_TRIG);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            echo_s1_q <= 1'b0;
            echo_s2_q <= 1'b0;
            period_q  <= '0;
            tmo_q     <= '0;
            pre_q     <= '0;
            dcnt_q    <= '0;
            dist_q    <= '0;
            flag_q    <= 1'b0;
            wp_q      <= '0;
            cnt_q     <= '0;
            newest_q  <= '0;
            oldest_q  <= '0;
            sv_q      <= 1'b0;
            timeout_q <= 1'b0;
            filled_q  <= 1'b0;
            trig_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            period_q  <= period_d;
            tmo_q     <= tmo_d;
            pre_q     <= pre_d;
            dcnt_q    <= dcnt_d;
            dist_q    <= dist_d;
            flag_q    <= flag_d;
            wp_q      <= wp_d;
            cnt_q     <= cnt_d;
            newest_q  <= newest_d;
            oldest_q  <= oldest_d;
            sv_q      <= sv_d;
            timeout_q <= timeout_d;
            filled_q  <= filled_d;
            trig_q    <= trig_d;
            if (state_q == S_STORE) begin
                mem_q[wp_q] <= dist_q;
            end
        end
    end

    assign trig         = trig_q;
    assign newest       = newest_q;
    assign oldest       = oldest_q;
    assign sample_valid = sv_q;
    assign timeout      = timeout_q;
    assign filled       = filled_q;

endmodule

// File: tb/tb_ranging_controller.sv
`timescale 1ns/1ps
module tb_ranging_controller;

    localparam int unsigned DW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          echo;
    logic          trig;
    logic [DW-1:0] newest;
    logic [DW-1:0] oldest;
    logic          sample_valid;
    logic          timeout;
    logic          filled;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;
    int last_rise = 0;

    ranging_controller #(
        .TRIG_CYCLES    (4),
        .PERIOD_CYCLES  (2000),
        .TIMEOUT_CYCLES (1000),
        .CYCLES_PER_UNIT(10),
        .MAX_DIST       (50),
        .DEPTH          (8),
        .DIST_W         (DW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .echo        (echo),
        .trig        (trig),
        .newest      (newest),
        .oldest      (oldest),
        .sample_valid(sample_valid),
        .timeout     (timeout),
        .filled      (filled)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full measurement: wait for the trigger, check its width and output
    // stability while high, drive an echo of 'width' clocks (0 = no echo),
    // optionally drop enable at echo clock 'drop_at', then check the sample.
    task automatic measure(input string tag, input int width, input int drop_at,
                           input int exp_new, input int exp_old,
                           input int exp_to, input int exp_fill);
        bit            got;
        bit            stable;
        int            hi;
        int            svc;
        logic [DW-1:0] n0, o0, cn, co;
        logic          ct, cf;
        got = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (trig === 1'b1) got = 1'b1;
        end
        chk({tag, ".trig_rise"}, 32'(got), 32'd1);
        last_rise = cyc;
        n0 = newest;
        o0 = oldest;
        stable = 1'b1;
        hi = 0;
        while (trig === 1'b1 && hi < 50) begin
            if (newest !== n0 || oldest !== o0) stable = 1'b0;
            hi++;
            @(negedge clk);
        end
        chk({tag, ".trig_width"}, 32'(hi), 32'd4);
        chk({tag, ".stable_in_trig"}, 32'(stable), 32'd1);
        repeat (3) @(negedge clk);
        got = 1'b0;
        svc = 0;
        cn = 'x; co = 'x; ct = 1'bx; cf = 1'bx;
        for (int i = 0; i < 3000 && !(got && i >= width); i++) begin
            echo = (i < width);
            if (i == drop_at) enable = 1'b0;
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                if (!got) begin
                    cn = newest; co = oldest; ct = timeout; cf = filled;
                end
                got = 1'b1;
                svc++;
            end
        end
        echo = 1'b0;
        @(negedge clk);
        if (sample_valid === 1'b1) svc++;
        chk({tag, ".sample_seen"}, 32'(got), 32'd1);
        chk({tag, ".newest"}, 32'(cn), 32'(exp_new));
        chk({tag, ".oldest"}, 32'(co), 32'(exp_old));
        chk({tag, ".timeout"}, 32'(ct), 32'(exp_to));
        chk({tag, ".filled"}, 32'(cf), 32'(exp_fill));
        chk({tag, ".valid_pulses"}, 32'(svc), 32'd1);
    endtask

    initial begin
        int  t1, t2, t3;
        bit  got;
        bit  saw;

        reset_n = 1'b0;
        enable  = 1'b0;
        echo    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.trig", 32'(trig), 32'd0);
        chk("rst.newest", 32'(newest), 32'd0);
        chk("rst.oldest", 32'(oldest), 32'd0);
        chk("rst.sample_valid", 32'(sample_valid), 32'd0);
        chk("rst.timeout", 32'(timeout), 32'd0);
        chk("rst.filled", 32'(filled), 32'd0);
        reset_n = 1'b1;

        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (trig !== 1'b0) saw = 1'b1;
        end
        chk("idle_disabled_no_trig", 32'(saw), 32'd0);

        enable = 1'b1;
        measure("m1_noecho", 0, -1, 50, 0, 1, 0);
        t1 = last_rise;
        measure("m2_w237", 237, -1, 23, 0, 0, 0);
        t2 = last_rise;
        chk("period_1_2", 32'(t2 - t1), 32'd2000);
        measure("m3_w100", 100, -1, 10, 0, 0, 0);
        t3 = last_rise;
        chk("period_2_3", 32'(t3 - t2), 32'd2000);

        // Reset while the trigger is high; trig must drop before any clock edge.
        got = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (trig === 1'b1) got = 1'b1;
        end
        chk("rst_mid.trig_rise", 32'(got), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid.trig_async", 32'(trig), 32'd0);
        chk("rst_mid.newest", 32'(newest), 32'd0);
        chk("rst_mid.oldest", 32'(oldest), 32'd0);
        chk("rst_mid.timeout", 32'(timeout), 32'd0);
        chk("rst_mid.filled", 32'(filled), 32'd0);
        chk("rst_mid.sample_valid", 32'(sample_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Buffer must read back as zeros (oldest) until the ninth store.
        for (int k = 1; k <= 9; k++) begin
            measure($sformatf("seq%0d", k), 10 * k, -1, k,
                    (k == 9) ? 1 : 0, 0, (k >= 8) ? 1 : 0);
        end

        measure("m_long1200", 1200, -1, 50, 2, 1, 1);
        measure("m_after_to", 55, -1, 5, 3, 0, 1);
        measure("m_drop_en", 150, 75, 15, 4, 0, 1);

        saw = 1'b0;
        repeat (2500) begin
            @(negedge clk);
            if (trig !== 1'b0) saw = 1'b1;
        end
        chk("disabled_no_trig", 32'(saw), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("reenable_trig", 32'(trig), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
